// File: rtl/regfile_wb_sink_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_sink_pkg : shared pipeline definitions for the register file
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_wb_sink_pkg;
  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CNTW = 2;

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

`default_nettype wire

// File: rtl/regfile_wb_sink_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_sink_if : write-back, ID read, load scoreboard and debug signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_wb_sink_if
  import regfile_wb_sink_pkg::*;
();
  logic          wreg_wb;
  logic [DW-1:0] RegFileWtAddr_wb;
  logic [DW-1:0] regWriteBackData_wb;
  logic          wb_is_load;
  reg_idx_t      rs_addr_id;
  reg_idx_t      rt_addr_id;
  logic [DW-1:0] rs_data_id;
  logic [DW-1:0] rt_data_id;
  logic          ld_issue_id;
  reg_idx_t      ld_dst_id;
  logic          id_advance;
  logic          stall_id;
  reg_idx_t      dbg_addr;
  logic [DW-1:0] dbg_data;

  modport master (
    output wreg_wb, RegFileWtAddr_wb, regWriteBackData_wb, wb_is_load,
    output rs_addr_id, rt_addr_id, ld_issue_id, ld_dst_id, id_advance, dbg_addr,
    input  rs_data_id, rt_data_id, stall_id, dbg_data
  );

  modport slave (
    input  wreg_wb, RegFileWtAddr_wb, regWriteBackData_wb, wb_is_load,
    input  rs_addr_id, rt_addr_id, ld_issue_id, ld_dst_id, id_advance, dbg_addr,
    output rs_data_id, rt_data_id, stall_id, dbg_data
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_sink_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard : per-register pending-load counters and load-use stall
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
  import regfile_wb_sink_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_wreg,
  input  reg_idx_t  i_waddr,
  input  wire logic i_wb_is_load,
  input  wire logic i_ld_issue,
  input  reg_idx_t  i_ld_dst,
  input  wire logic i_id_advance,
  input  reg_idx_t  i_rs,
  input  reg_idx_t  i_rt,
  output logic      o_stall
);
  localparam logic [CNTW-1:0] c_CNT_MAX = '1;
  localparam logic [CNTW-1:0] c_CNT_ONE = CNTW'(1);

  logic [CNTW-1:0] w_cnt [NREG];
  logic            w_clr_rs;
  logic            w_clr_rt;

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    if (r == 0) begin : g_zero
      assign w_cnt[r] = '0;
    end else begin : g_live
      logic [CNTW-1:0] r_cnt;
      logic            w_inc;
      logic            w_dec;

      assign w_inc = i_id_advance && i_ld_issue && (i_ld_dst == reg_idx_t'(r));
      assign w_dec = i_wreg && i_wb_is_load && (i_waddr == reg_idx_t'(r)) && (r_cnt != '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec && (r_cnt != c_CNT_MAX)) begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end else if (w_dec && !w_inc) begin
          r_cnt <= r_cnt - c_CNT_ONE;
        end
      end

      assign w_cnt[r] = r_cnt;

      // More loads in flight than the pipe can hold means the ID/WB protocol broke.
      a_no_saturate: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_inc && !w_dec && (r_cnt == c_CNT_MAX)));
    end
  end

  // The last outstanding load retiring this cycle reaches ID through the bypass.
  assign w_clr_rs = i_wreg && i_wb_is_load && (i_waddr == i_rs) && (w_cnt[i_rs] == c_CNT_ONE);
  assign w_clr_rt = i_wreg && i_wb_is_load && (i_waddr == i_rt) && (w_cnt[i_rt] == c_CNT_ONE);

  assign o_stall = ((i_rs != REG_ZERO) && (w_cnt[i_rs] != '0) && !w_clr_rs) ||
                   ((i_rt != REG_ZERO) && (w_cnt[i_rt] != '0) && !w_clr_rt);
endmodule

`default_nettype wire

// File: rtl/regfile_wb_sink.sv
// ---------------------------------------------------------------------------
// regfile_wb_sink : 32x32 register file with WB write-through and load stall
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wb_sink
  import regfile_wb_sink_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst_n,
  regfile_wb_sink_if.slave  bus
);
  reg_idx_t      w_waddr;
  logic          w_wr_en;
  logic          w_unused_addr_hi;
  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] r_dbg;
  logic [DW-1:0] w_rs_data;
  logic [DW-1:0] w_rt_data;

  assign w_waddr          = bus.RegFileWtAddr_wb[AW-1:0];
  assign w_unused_addr_hi = ^bus.RegFileWtAddr_wb[DW-1:AW];
  assign w_wr_en          = bus.wreg_wb && (w_waddr != REG_ZERO);

  // Entry 0 is never written, so it holds zero from reset onwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_dbg <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[w_waddr] <= bus.regWriteBackData_wb;
      end
      r_dbg <= r_regs[bus.dbg_addr];
    end
  end

  always_comb begin
    w_rs_data = r_regs[bus.rs_addr_id];
    if (bus.rs_addr_id == REG_ZERO) begin
      w_rs_data = '0;
    end else if (bus.wreg_wb && (w_waddr == bus.rs_addr_id)) begin
      w_rs_data = bus.regWriteBackData_wb;
    end
  end

  always_comb begin
    w_rt_data = r_regs[bus.rt_addr_id];
    if (bus.rt_addr_id == REG_ZERO) begin
      w_rt_data = '0;
    end else if (bus.wreg_wb && (w_waddr == bus.rt_addr_id)) begin
      w_rt_data = bus.regWriteBackData_wb;
    end
  end

  assign bus.rs_data_id = w_rs_data;
  assign bus.rt_data_id = w_rt_data;
  assign bus.dbg_data   = r_dbg;

  regfile_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wreg       (bus.wreg_wb),
    .i_waddr      (w_waddr),
    .i_wb_is_load (bus.wb_is_load),
    .i_ld_issue   (bus.ld_issue_id),
    .i_ld_dst     (bus.ld_dst_id),
    .i_id_advance (bus.id_advance),
    .i_rs         (bus.rs_addr_id),
    .i_rt         (bus.rt_addr_id),
    .o_stall      (bus.stall_id)
  );
endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sink.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_sink : scoreboard-driven bench for regfile_wb_sink
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_sink;
  import regfile_wb_sink_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regfile_wb_sink_if bus ();

  regfile_wb_sink dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        st;
    logic [31:0] dbg;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (bus.wreg_wb && bus.RegFileWtAddr_wb[4:0] == a) return bus.regWriteBackData_wb;
    return m_reg[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    logic clr;
    clr = bus.wreg_wb && bus.wb_is_load && (bus.RegFileWtAddr_wb[4:0] == a) && (m_cnt[a] == 1);
    return (a != 5'd0) && (m_cnt[a] != 0) && !clr;
  endfunction

  task automatic step(input string tag, input logic wreg, input logic [31:0] wa,
                      input logic [31:0] wd, input logic isl, input logic [4:0] rs,
                      input logic [4:0] rt, input logic ldi, input logic [4:0] ldd,
                      input logic adv, input logic [4:0] da);
    exp_t e;
    logic [4:0] w5;
    @(negedge clk);
    bus.wreg_wb = wreg;  bus.RegFileWtAddr_wb = wa; bus.regWriteBackData_wb = wd;
    bus.wb_is_load = isl; bus.rs_addr_id = rs; bus.rt_addr_id = rt;
    bus.ld_issue_id = ldi; bus.ld_dst_id = ldd; bus.id_advance = adv; bus.dbg_addr = da;
    e.tag = tag;
    e.rs  = m_rd(rs);
    e.rt  = m_rd(rt);
    e.st  = m_busy(rs) || m_busy(rt);
    e.dbg = m_reg[da];
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    chk({e.tag, "_rs"}, bus.rs_data_id, e.rs);
    chk({e.tag, "_rt"}, bus.rt_data_id, e.rt);
    chk({e.tag, "_stall"}, {31'd0, bus.stall_id}, {31'd0, e.st});
    @(posedge clk);
    w5 = wa[4:0];
    begin
      logic inc, dec;
      for (int r = 1; r < 32; r++) begin
        inc = adv && ldi && (ldd == r[4:0]);
        dec = wreg && isl && (w5 == r[4:0]) && (m_cnt[r] != 0);
        if (inc && !dec && m_cnt[r] < 3) m_cnt[r]++;
        else if (dec && !inc) m_cnt[r]--;
      end
    end
    if (wreg && w5 != 5'd0) m_reg[w5] = wd;
    #1;
    chk({e.tag, "_dbg"}, bus.dbg_data, e.dbg);
  endtask

  task automatic idle(input string tag, input logic [4:0] rs, input logic [4:0] rt);
    step(tag, 1'b0, 32'd0, 32'd0, 1'b0, rs, rt, 1'b0, 5'd0, 1'b0, rs);
  endtask

  task automatic issue(input string tag, input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    step(tag, 1'b0, 32'd0, 32'd0, 1'b0, rs, rt, 1'b1, dst, 1'b1, rs);
  endtask

  task automatic async_reset(input string tag, input logic [4:0] rs, input logic [4:0] rt);
    @(negedge clk);
    bus.wreg_wb = 1'b0; bus.wb_is_load = 1'b0; bus.ld_issue_id = 1'b0;
    bus.id_advance = 1'b0; bus.rs_addr_id = rs; bus.rt_addr_id = rt;
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    chk({tag, "_rs"}, bus.rs_data_id, 32'd0);
    chk({tag, "_rt"}, bus.rt_data_id, 32'd0);
    chk({tag, "_stall"}, {31'd0, bus.stall_id}, 32'd0);
    chk({tag, "_dbg"}, bus.dbg_data, 32'd0);
    chk({tag, "_noX"}, {31'd0, ((^{bus.rs_data_id, bus.rt_data_id, bus.stall_id, bus.dbg_data}) === 1'bx)}, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0]  d;
    logic [4:0]  a;
    logic [31:0] wa;
    logic        ldi;
    bus.wreg_wb = 1'b0; bus.RegFileWtAddr_wb = '0; bus.regWriteBackData_wb = '0;
    bus.wb_is_load = 1'b0; bus.rs_addr_id = '0; bus.rt_addr_id = '0;
    bus.ld_issue_id = 1'b0; bus.ld_dst_id = '0; bus.id_advance = 1'b0; bus.dbg_addr = '0;
    model_clear();
    #12 rst_n = 1'b1;

    // Fill with arbitrary contents, then reset asynchronously and read back.
    for (int i = 1; i < 32; i++)
      step("fill", 1'b1, i, $urandom, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    idle("fill_rd", 5'd5, 5'd31);
    async_reset("rst", 5'd5, 5'd31);
    idle("post_rst", 5'd5, 5'd31);

    step("wr3", 1'b1, 32'h0000_0003, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rd3", 1'b0, 32'd0, 32'd0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
    chk("rd3_lit", bus.rs_data_id, 32'hDEAD_BEEF);
    step("wr3_hi", 1'b1, 32'hFFFF_FFE3, 32'h1357_2468, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
    idle("rd3_hi", 5'd3, 5'd0);
    chk("rd3_hi_lit", bus.rs_data_id, 32'h1357_2468);

    step("wr0", 1'b1, 32'd0, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    idle("rd0", 5'd0, 5'd0);
    issue("ld0", 5'd0, 5'd0, 5'd0);
    idle("ld0_rd", 5'd0, 5'd0);

    step("byp7", 1'b1, 32'd7, 32'hA5A5_0007, 1'b0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7);
    idle("byp7_after", 5'd0, 5'd7);

    issue("ld9", 5'd9, 5'd9, 5'd0);
    idle("ld9_wait1", 5'd9, 5'd0);
    idle("ld9_wait2", 5'd9, 5'd0);
    step("ld9_wb", 1'b1, 32'd9, 32'hCAFE_0009, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9);
    idle("ld9_done", 5'd9, 5'd0);

    issue("ld4a", 5'd4, 5'd0, 5'd4);
    issue("ld4b", 5'd4, 5'd0, 5'd4);
    idle("ld4_wait", 5'd0, 5'd4);
    step("ld4_wb1", 1'b1, 32'd4, 32'h0000_4441, 1'b1, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 5'd4);
    step("ld4_wb2", 1'b1, 32'd4, 32'h0000_4442, 1'b1, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 5'd4);
    idle("ld4_done", 5'd0, 5'd4);
    issue("ld4c", 5'd4, 5'd0, 5'd0);
    issue("ld4d", 5'd4, 5'd0, 5'd0);
    idle("ld4_busy", 5'd4, 5'd0);
    async_reset("rst_cnt", 5'd4, 5'd4);
    idle("rst_cnt_after", 5'd4, 5'd4);

    for (int i = 0; i < 250; i++) begin
      d   = 5'($urandom_range(0, 31));
      ldi = ($urandom_range(0, 2) == 0) && (m_cnt[d] < 2);
      a   = ($urandom_range(0, 1) == 0) ? d : 5'($urandom_range(0, 31));
      wa  = {$urandom, 5'($urandom_range(0, 31))} >> 0;
      wa  = {wa[31:5], (($urandom_range(0, 1) == 0) ? a : wa[4:0])};
      step("rand", 1'($urandom), wa, $urandom, 1'($urandom), a,
           5'($urandom_range(0, 31)), ldi, d, 1'b1, 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
